mul_ctrl: RTL and testbench

//  Multi-cycle controller for the combinational signed radix-4 Booth multiplier in the ALU.
//  - Accepts one operand pair through a valid/ready handshake and registers it.
//  - Holds the operands stable on an internal mul instance for WAIT_CYCLES clocks, treated as a multicycle path.
//  - Captures the 64-bit product into the HI/LO result registers and presents it with a valid/ready handshake.
//  - Sits between the CPU control unit and the HI/LO register file.

---
 rtl/mul_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mul_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_ctrl (with helper mul_booth_r4)
// Purpose  : Multicycle valid/ready controller around a combinational signed
//            radix-4 Booth multiplier. Optional macro: MUL_ZERO_SKIP_EN.
// Revision : 1.0
// ============================================================================

module mul_booth_r4 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   mcand_i,
    input  logic [DATA_WIDTH-1:0]   mplier_i,
    output logic [2*DATA_WIDTH-1:0] prod_o
);
    localparam int NPP = (DATA_WIDTH + 1) / 2;
    localparam int PW  = 2 * DATA_WIDTH;

    logic signed [PW-1:0]    w_mcand_sx;
    logic signed [2*NPP-1:0] w_mplier_sx;
    logic [2*NPP:0]          w_mplier_ext;
    logic [PW-1:0]           w_pp_sh [NPP];
    logic [PW-1:0]           w_acc;

    assign w_mcand_sx   = PW'($signed(mcand_i));
    assign w_mplier_sx  = (2*NPP)'($signed(mplier_i));
    assign w_mplier_ext = {w_mplier_sx, 1'b0};

    // Each overlapping bit triplet of the multiplier selects a digit in {-2..+2}.
    for (genvar i = 0; i < NPP; i++) begin : g_pp
        logic [2:0]    w_trip;
        logic [PW-1:0] w_pp;

        assign w_trip = w_mplier_ext[2*i+2 -: 3];

        always_comb begin
            case (w_trip)
                3'b001, 3'b010: w_pp = w_mcand_sx;
                3'b011:         w_pp = w_mcand_sx << 1;
                3'b100:         w_pp = -(w_mcand_sx << 1);
                3'b101, 3'b110: w_pp = -w_mcand_sx;
                default:        w_pp = '0;
            endcase
        end

        assign w_pp_sh[i] = w_pp << (2*i);
    end

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NPP; k++) begin
            w_acc = w_acc + w_pp_sh[k];
        end
    end

    assign prod_o = w_acc;

endmodule

module mul_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_q,
    input  logic [DATA_WIDTH-1:0] op_m,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy
);
    localparam logic [CNT_WIDTH-1:0] c_WAIT_LOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0]   hi_q, hi_d;
    logic [DATA_WIDTH-1:0]   lo_q, lo_d;
    logic                    out_valid_q, out_valid_d;

    logic [2*DATA_WIDTH-1:0] w_product;
    logic                    w_zero_op;

    // Operands come from registers only, so the multiplier is a multicycle path.
    mul_booth_r4 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .prod_o   (w_product)
    );

`ifdef MUL_ZERO_SKIP_EN
    // A zero operand yields a zero product at once; capture on the very next edge.
    assign w_zero_op = (op_q == '0) || (op_m == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand_d  = op_q;
                        mplier_d = op_m;
                        cnt_d    = w_zero_op ? '0 : c_WAIT_LOAD;
                        state_d  = S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = w_product;
                        out_valid_d  = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_ctrl.sv
`default_nettype none
// Testbench for mul_ctrl: latency-counting reference model checked every cycle,
// plus directed operations with hand-computed products.
module tb_mul_ctrl;
    localparam int DW = 32;
    localparam int W  = 2;
`ifdef MUL_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W;
`endif

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] op_q      = '0;
    logic [DW-1:0] op_m      = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_ctrl #(
        .DATA_WIDTH  (DW),
        .WAIT_CYCLES (W),
        .CNT_WIDTH   (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_q      (op_q),
        .op_m      (op_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle / waiting m_left edges for the product / result held.
    bit          m_idle  = 1'b1;
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    logic [63:0] m_prod  = '0;
    logic [63:0] m_res   = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= 0;
            m_res   <= '0;
        end else if (flush) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_prod <= 64'(longint'($signed(op_q)) * longint'($signed(op_m)));
                m_left <= ((op_q == '0) || (op_m == '0)) ? ZLAT : W;
                m_idle <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_res   <= m_prod;
                m_valid <= 1'b1;
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("cyc_in_ready", 64'(in_ready), 64'(m_idle));
            check("cyc_busy", 64'(busy), 64'(!m_idle));
            check("cyc_out_valid", 64'(out_valid), 64'(m_valid));
            check("cyc_result", {hi, lo}, m_res);
        end
    end

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        op_q     = a;
        op_m     = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic expect_lat(input int lat);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #2;
            check("latency_out_valid", 64'(out_valid), 64'(k == lat));
        end
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int lat, input logic [63:0] exp);
        send(a, b);
        expect_lat(lat);
        check("product", {hi, lo}, exp);
        @(posedge clk); #2;
        check("ready_after_take", 64'(in_ready), 64'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #2;

        run_op(32'd7, 32'hFFFFFFFD, W, 64'hFFFFFFFF_FFFFFFEB);
        run_op(32'h80000000, 32'h80000000, W, 64'h40000000_00000000);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, W, 64'h00000000_00000001);
        run_op(32'hFFFFFFFB, 32'hFFFFFFFB, W, 64'h00000000_00000019);
        run_op(32'h7FFFFFFF, 32'h7FFFFFFF, W, 64'h3FFFFFFF_00000001);
        run_op(32'h80000000, 32'h00000001, W, 64'hFFFFFFFF_80000000);
        run_op(32'hFFFFFFFF, 32'h80000000, W, 64'h00000000_80000000);
        run_op(32'h12345678, 32'h00000002, W, 64'h00000000_2468ACF0);

        // Backpressure: result held while the consumer stalls.
        out_ready = 1'b0;
        send(32'd1000, 32'hFFFFFFFF);
        expect_lat(W);
        repeat (5) begin
            @(posedge clk); #2;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_result", {hi, lo}, 64'hFFFFFFFF_FFFFFC18);
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);

        // Flush mid-operation keeps the previous result.
        run_op(32'd6, 32'd7, W, 64'd42);
        send(32'd5, 32'd6);
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        check("flush_hilo", {hi, lo}, 64'd42);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (4) begin
            @(posedge clk); #2;
            check("flush_no_valid", 64'(out_valid), 64'd0);
        end

        // Flush beats a same-cycle accept.
        op_q     = 32'd9;
        op_m     = 32'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #2;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_accept_busy", 64'(busy), 64'd0);
        @(posedge clk); #2;
        check("flush_accept_idle", 64'(busy), 64'd0);
        check("flush_accept_hilo", {hi, lo}, 64'd42);

        // Asynchronous reset mid-operation.
        send(32'd100, 32'd200);
        #1 reset_n = 1'b0;
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_hilo", {hi, lo}, 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        run_op(32'd3, 32'd4, W, 64'd12);

        // Zero operand.
        run_op(32'd0, 32'd123, ZLAT, 64'd0);
        run_op(32'd3, 32'd4, W, 64'd12);
        run_op(32'hFFFFFF85, 32'd0, ZLAT, 64'd0);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
